// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction fields into 26-bit words, queues
// them in a small FIFO and drains them as sequential instruction-memory writes
// starting at BASE_ADDR.
// Optional feature macro: ENC_ILLEGAL_TRAP_EN (drop class-10 form-1 bundles
// and raise a sticky err flag instead of encoding them).
module inst_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [9:0]        imm10,
  input  logic [19:0]       imm20,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [25:0]       out_word,
  input  logic              clr_addr,
  output logic              err,
  output logic [15:0]       words_out
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [25:0]       enc_word;
  logic [25:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] addr;

  // Field packing: the inverse of the decoder's extraction, selected by class and form bit
  always_comb begin
    enc_word = '0;
    case (opcode[5:4])
      2'b00: begin
        if (opcode[3:0] == 4'd0)
          enc_word = {opcode, imm20};
        else
          enc_word = {opcode, rd, rn, (opcode[3] ? imm10 : {rm, 5'b0})};
      end
      2'b01:   enc_word = {opcode, rd, rn, (opcode[3] ? imm10 : {rm, 5'b0})};
      2'b10:   enc_word = {opcode, rd, rn, imm10};
      default: begin
        if (opcode[3])
          enc_word = {opcode, imm20};
        else
          enc_word = {opcode, rd, rn, imm10};
      end
    endcase
  end

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_word  = empty ? 26'd0 : mem[rd_ptr];
  assign out_addr  = addr;

`ifdef ENC_ILLEGAL_TRAP_EN
  logic illegal;
  logic err_q;

  assign illegal = (opcode[5:4] == 2'b10) && opcode[3];
  assign push    = in_valid && in_ready && !illegal;
  assign err     = err_q;

  // Sticky trap: an accepted illegal bundle is swallowed and flagged until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (in_valid && in_ready && illegal)
      err_q <= 1'b1;
  end
`else
  assign push = in_valid && in_ready;
  assign err  = 1'b0;
`endif

  // Storage array; no reset needed because reads are masked while empty
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= enc_word;
  end

  // FIFO pointers and occupancy; push and pop together leave occupancy unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write address counter; clr_addr takes priority over the post-write increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      addr <= BASE;
    else if (clr_addr)
      addr <= BASE;
    else if (pop)
      addr <= addr + 1'b1;
  end

  // Completed-write counter, free-running 16-bit wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      words_out <= '0;
    else if (pop)
      words_out <= words_out + 1'b1;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed testbench for inst_encoder. A second instance with ADDR_W=2 shares
// all inputs so address wrap can be observed alongside the wide-address DUT.
module tb_inst_encoder;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic        inReady2;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [9:0]  imm10;
  logic [19:0] imm20;
  logic        outValid;
  logic        outValid2;
  logic        outReady;
  logic [9:0]  outAddr;
  logic [1:0]  outAddr2;
  logic [25:0] outWord;
  logic [25:0] outWord2;
  logic        clrAddr;
  logic        err;
  logic        err2;
  logic [15:0] wordsOut;
  logic [15:0] wordsOut2;

  int checks = 0;
  int errors = 0;

  logic [5:0]  vecOp   [4] = '{6'h10, 6'h00, 6'h18, 6'h38};
  logic [4:0]  vecRd   [4] = '{5'd3, 5'd0, 5'd1, 5'd0};
  logic [4:0]  vecRn   [4] = '{5'd4, 5'd0, 5'd2, 5'd0};
  logic [4:0]  vecRm   [4] = '{5'd5, 5'd0, 5'd0, 5'd0};
  logic [9:0]  vecI10  [4] = '{10'd0, 10'd0, 10'h3FF, 10'd0};
  logic [19:0] vecI20  [4] = '{20'd0, 20'hABCDE, 20'd0, 20'h12345};
  logic [25:0] vecWord [4] = '{26'h10190A0, 26'h00ABCDE, 26'h1808BFF, 26'h3812345};

  inst_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .imm10(imm10), .imm20(imm20),
    .out_valid(outValid), .out_ready(outReady), .out_addr(outAddr),
    .out_word(outWord), .clr_addr(clrAddr), .err(err), .words_out(wordsOut)
  );

  inst_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady2),
    .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .imm10(imm10), .imm20(imm20),
    .out_valid(outValid2), .out_ready(outReady), .out_addr(outAddr2),
    .out_word(outWord2), .clr_addr(clrAddr), .err(err2), .words_out(wordsOut2)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] d, input logic [4:0] n,
                               input logic [4:0] m, input logic [9:0] i10, input logic [19:0] i20);
    opcode  = op;
    rd      = d;
    rn      = n;
    rm      = m;
    imm10   = i10;
    imm20   = i20;
    inValid = 1'b1;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; clrAddr = 1'b0;
    opcode = '0; rd = '0; rn = '0; rm = '0; imm10 = '0; imm20 = '0;
    stepClk();
    stepClk();
    rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_out_addr", 32'(outAddr), 32'd0);
    checkOutput("rst_words_out", 32'(wordsOut), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_out_word", 32'(outWord), 32'd0);

    $display("[TB] back-to-back encoding, out_ready=1");
    outReady = 1'b1;
    applyStimulus(vecOp[0], vecRd[0], vecRn[0], vecRm[0], vecI10[0], vecI20[0]);
    stepClk();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("enc_valid_%0d", i), 32'(outValid), 32'd1);
      checkOutput($sformatf("enc_word_%0d", i), 32'(outWord), 32'(vecWord[i]));
      checkOutput($sformatf("enc_addr_%0d", i), 32'(outAddr), 32'(i));
      checkOutput($sformatf("enc_addr2_%0d", i), 32'(outAddr2), 32'(i));
      if (i < 3)
        applyStimulus(vecOp[i+1], vecRd[i+1], vecRn[i+1], vecRm[i+1], vecI10[i+1], vecI20[i+1]);
      else
        inValid = 1'b0;
      stepClk();
    end
    checkOutput("enc_words_out", 32'(wordsOut), 32'd4);
    checkOutput("enc_drained", 32'(outValid), 32'd0);

    $display("[TB] address wrap and clear");
    applyStimulus(6'h20, 5'd7, 5'd8, 5'd0, 10'h155, 20'd0);
    stepClk();
    inValid = 1'b0;
    checkOutput("wrap_word", 32'(outWord), 32'h203A155);
    checkOutput("wrap_addr_wide", 32'(outAddr), 32'd4);
    checkOutput("wrap_addr_narrow", 32'(outAddr2), 32'd0);
    clrAddr = 1'b1;
    stepClk();
    clrAddr = 1'b0;
    checkOutput("clr_addr_wide", 32'(outAddr), 32'd0);
    checkOutput("clr_addr_narrow", 32'(outAddr2), 32'd0);
    checkOutput("clr_words_out", 32'(wordsOut), 32'd5);
    checkOutput("clr_empty", 32'(outValid), 32'd0);

    $display("[TB] backpressure");
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecOp[i], vecRd[i], vecRn[i], vecRm[i], vecI10[i], vecI20[i]);
      stepClk();
      checkOutput($sformatf("bp_in_ready_%0d", i), 32'(inReady), (i < 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("bp_head_%0d", i), 32'(outWord), 32'(vecWord[0]));
      checkOutput($sformatf("bp_addr_%0d", i), 32'(outAddr), 32'd0);
    end
    applyStimulus(6'h20, 5'd7, 5'd8, 5'd0, 10'h155, 20'd0);
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_drain_valid_%0d", i), 32'(outValid), 32'd1);
      checkOutput($sformatf("bp_drain_word_%0d", i), 32'(outWord), 32'(vecWord[i]));
      checkOutput($sformatf("bp_drain_addr_%0d", i), 32'(outAddr), 32'(i));
      stepClk();
      inValid = 1'b0;
      checkOutput($sformatf("bp_drain_ready_%0d", i), 32'(inReady), 32'd1);
    end
    checkOutput("bp_empty", 32'(outValid), 32'd0);
    checkOutput("bp_words_out", 32'(wordsOut), 32'd9);

    $display("[TB] reset mid-operation");
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecOp[i], vecRd[i], vecRn[i], vecRm[i], vecI10[i], vecI20[i]);
      stepClk();
    end
    inValid = 1'b0;
    checkOutput("mid_queued", 32'(outValid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_out_valid", 32'(outValid), 32'd0);
    checkOutput("mid_words_out", 32'(wordsOut), 32'd0);
    checkOutput("mid_in_ready", 32'(inReady), 32'd1);
    checkOutput("mid_out_word", 32'(outWord), 32'd0);
    checkOutput("mid_out_addr", 32'(outAddr), 32'd0);
    #1 rst = 1'b0;
    stepClk();
    outReady = 1'b1;
    applyStimulus(6'h20, 5'd7, 5'd8, 5'd0, 10'h155, 20'd0);
    stepClk();
    inValid = 1'b0;
    checkOutput("post_rst_word", 32'(outWord), 32'h203A155);
    checkOutput("post_rst_addr", 32'(outAddr), 32'd0);
    stepClk();
    checkOutput("post_rst_words_out", 32'(wordsOut), 32'd1);
    checkOutput("post_rst_empty", 32'(outValid), 32'd0);

    $display("[TB] illegal form op=0x28");
    outReady = 1'b0;
    applyStimulus(6'h28, 5'd1, 5'd2, 5'd0, 10'h010, 20'd0);
    stepClk();
    inValid = 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
    checkOutput("ill_no_push", 32'(outValid), 32'd0);
    checkOutput("ill_err", 32'(err), 32'd1);
    stepClk();
    checkOutput("ill_err_sticky", 32'(err), 32'd1);
`else
    checkOutput("ill_pushed", 32'(outValid), 32'd1);
    checkOutput("ill_word", 32'(outWord), 32'h2808810);
    checkOutput("ill_addr", 32'(outAddr), 32'd1);
    checkOutput("ill_err", 32'(err), 32'd0);
    outReady = 1'b1;
    stepClk();
    checkOutput("ill_words_out", 32'(wordsOut), 32'd2);
`endif

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
